johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 4-stage JK Johnson counter. Samples the counter's raw state vector and produces a registered one-hot phase, the phase index, a lap counter, and fault flags. Detects illegal codes and out-of-sequence steps so that downstream logic never acts on a corrupted ring.

## Interface
Parameters:
- `STAGES`, default 4: Johnson stage count W. The ring has 2W legal phases.
- `LAP_W`, default 8: lap counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rs`, in, 1: reset, asynchronous and active-high.
- `en`, in, 1: sample strobe. `jq` is evaluated only on cycles where `en` is 1.
- `jq`, in, STAGES: counter state, with `jq[0]` = first stage (q1) and `jq[STAGES-1]` = last stage.
- `clr_err`, in, 1: clears `fault` and leaves FAULT.
- `phase`, out, 2*STAGES: one-hot decoded phase. All zeros when not locked.
- `phase_idx`, out, clog2(2*STAGES): phase index k.
- `valid`, out, 1: `phase`, `phase_idx` and `lap_cnt` are meaningful.
- `lap_cnt`, out, LAP_W: completed laps. Wraps modulo 2^LAP_W.
- `lap_pulse`, out, 1: one-cycle pulse on each wrap from 2W-1 to 0.
- `step_err`, out, 1: one-cycle pulse on a legal but non-adjacent phase step.
- `fault`, out, 1: sticky illegal-code flag.

## Operation
Code-to-index mapping:
- For k = 0..W: `jq` holds the low k bits as 1 and the rest 0. Example for W=4: k=0 is 0000, k=1 is 0001, k=4 is 1111.
- For k = W+1..2W-1: `jq` holds the high (2W-k) bits as 1 and the rest 0. Example: k=5 is 1110, k=7 is 1000.
- Any other pattern is illegal. For W=4 the 8 illegal codes are 0010, 0100, 0101, 0110, 1001, 1010, 1011, 1101.

States:
- **ACQUIRE** (entered on reset):
  - `valid` = 0.
  - On `en` with a legal code: latch k, move to LOCKED, set `valid` = 1. No lap is counted.
  - On `en` with an illegal code: move to FAULT.
- **LOCKED**, on each `en` sample:
  - idx = (prev+1) mod 2W: advance. If prev = 2W-1, `lap_cnt`+1 and `lap_pulse`.
  - idx = prev: hold. This covers a stalled counter and is not an error.
  - Legal but any other idx: pulse `step_err`, move to ACQUIRE, `valid` = 0. `lap_cnt` is kept.
  - Illegal code: move to FAULT.
- **FAULT**:
  - `fault` = 1, `valid` = 0, `phase` = 0.
  - Exit is controlled by the macro described under Configuration.
- `clr_err` in any state:
  - Clears `fault` and goes to ACQUIRE.
  - `clr_err` takes priority over a sample in the same cycle. That sample is ignored.
- Cycles with `en` = 0: all state and outputs hold, and pulses deassert.

## Timing
- Reset values: `phase` = 0, `phase_idx` = 0, `valid` = 0, `lap_cnt` = 0, `lap_pulse` = 0, `step_err` = 0, `fault` = 0, state = ACQUIRE.
- Reset may be asserted mid-lap. The effect is immediate and asynchronous, and the lap count is lost.
- All outputs are registered. Latency is one cycle: a sample with `en` at edge n appears on the outputs after edge n.
- `lap_pulse` and `step_err` are high for exactly one cycle per event, even if `en` stays high.
- Simultaneous wrap and fault cannot occur, because an illegal code yields no index.
- Back-to-back `en` on every cycle is supported at full rate.

## Configuration
- Macro: `JOHNSON_DEC_AUTO_RELOCK_EN`.
- **Defined:**
  - In FAULT, the first `en` sample with a legal code moves the block to ACQUIRE-equivalent lock. It latches k and enters LOCKED with `valid` = 1.
  - `fault` stays set until `clr_err`.
- **Undefined:**
  - FAULT is left only via `clr_err` or `rs`.
  - Legal samples in FAULT are ignored.

## Test plan
- **Reset then lock:** apply reset, then `en` = 1 with `jq` stepping 0000, 0001, 0011, ..., 1000, 0000.
  - `valid` = 1 one cycle after the first sample.
  - `phase` walks 0x01 through 0x80.
  - `lap_pulse` fires once, and `lap_cnt` = 1.
- **Lap wrap:** run 256 full laps with LAP_W = 8. `lap_cnt` returns to 0, with 256 `lap_pulse` pulses.
- **Step error:** lock at k=2 (0011), then apply 1110 (k=5).
  - `step_err` pulses once and `valid` = 0.
  - The next sample 1100 (k=6) relocks without a lap.
- **Illegal code:** while locked at 0111, apply 0101.
  - `fault` = 1, `valid` = 0, `phase` = 0.
  - With the macro defined, the next 0000 gives `valid` = 1 and `fault` stays 1.
  - With the macro undefined, the block stays in FAULT until `clr_err`.
- **Hold and gating:**
  - `jq` repeated at 1111 for 5 samples: `phase` stays 0x10 with no `step_err`.
  - `en` = 0 while `jq` changes arbitrarily: outputs do not change.
- **Async reset mid-lap:** assert `rs` between clock edges at k=5.
  - All outputs take their reset values immediately, before the next edge.
  - `lap_cnt` = 0.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Samples the raw state vector of a STAGES-deep Johnson counter and tracks
// it as a ring of 2*STAGES phases. Outputs a registered one-hot phase, the
// phase index, a lap counter, and step/illegal-code fault indications.
//
// Optional feature: define JOHNSON_DEC_AUTO_RELOCK_EN to let the block relock
// out of FAULT on the first legal sample. The sticky fault flag stays set
// until clr_err. With the macro undefined, FAULT is left only via clr_err or rs.

module johnson_phase_decoder #(
  parameter int STAGES = 4,
  parameter int LAP_W  = 8
) (
  input  logic                              clk,
  input  logic                              rs,
  input  logic                              en,
  input  logic [STAGES-1:0]                 jq,
  input  logic                              clr_err,
  output logic [2*STAGES-1:0]               phase,
  output logic [$clog2(2*STAGES)-1:0]       phase_idx,
  output logic                              valid,
  output logic [LAP_W-1:0]                  lap_cnt,
  output logic                              lap_pulse,
  output logic                              step_err,
  output logic                              fault
);

  localparam int PHASES = 2 * STAGES;
  localparam int IDX_W  = $clog2(PHASES);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  // Legal Johnson code for ring position k: the first STAGES+1 positions fill
  // with ones from the low end, the remaining ones drain out from the low end.
  function automatic logic [STAGES-1:0] pattern_f(input int k);
    logic [STAGES-1:0] p;
    for (int i = 0; i < STAGES; i++) begin
      p[i] = (k <= STAGES) ? (i < k) : (i >= (k - STAGES));
    end
    return p;
  endfunction

  // One-hot expansion of a phase index.
  function automatic logic [PHASES-1:0] onehot_f(input logic [IDX_W-1:0] idx);
    logic [PHASES-1:0] o;
    o = {PHASES{1'b0}};
    o[idx] = 1'b1;
    return o;
  endfunction

  state_e               state_q;
  logic [PHASES-1:0]    phase_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 valid_q;
  logic [LAP_W-1:0]     lap_cnt_q;
  logic                 lap_pulse_q;
  logic                 step_err_q;
  logic                 fault_q;

  logic                 dec_legal;
  logic [IDX_W-1:0]     dec_idx;
  logic [IDX_W-1:0]     next_idx_d;
  logic                 wrap_d;

  // Decode the sampled code; legal patterns are unique so OR-merging hits is safe.
  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = {IDX_W{1'b0}};
    for (int k = 0; k < PHASES; k++) begin
      dec_legal = dec_legal | (jq == pattern_f(k));
      dec_idx   = dec_idx | ((jq == pattern_f(k)) ? IDX_W'(k) : {IDX_W{1'b0}});
    end
  end

  // Expected successor of the locked phase, and whether that step closes a lap.
  always_comb begin
    wrap_d     = (idx_q == IDX_W'(PHASES - 1));
    next_idx_d = wrap_d ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
  end

  // Lock/track/fault state machine with all outputs registered.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q     <= ST_ACQUIRE;
      phase_q     <= {PHASES{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      valid_q     <= 1'b0;
      lap_cnt_q   <= {LAP_W{1'b0}};
      lap_pulse_q <= 1'b0;
      step_err_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      lap_pulse_q <= 1'b0;
      step_err_q  <= 1'b0;
      if (clr_err) begin
        // Clearing wins over a same-cycle sample; that sample is dropped.
        state_q <= ST_ACQUIRE;
        fault_q <= 1'b0;
        valid_q <= 1'b0;
        phase_q <= {PHASES{1'b0}};
      end else if (en) begin
        case (state_q)
          ST_ACQUIRE: begin
            if (dec_legal) begin
              state_q <= ST_LOCKED;
              idx_q   <= dec_idx;
              phase_q <= onehot_f(dec_idx);
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
              valid_q <= 1'b0;
              phase_q <= {PHASES{1'b0}};
            end
          end
          ST_LOCKED: begin
            if (!dec_legal) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
              valid_q <= 1'b0;
              phase_q <= {PHASES{1'b0}};
            end else if (dec_idx == next_idx_d) begin
              idx_q   <= dec_idx;
              phase_q <= onehot_f(dec_idx);
              if (wrap_d) begin
                lap_cnt_q   <= lap_cnt_q + LAP_W'(1);
                lap_pulse_q <= 1'b1;
              end else begin
                lap_cnt_q   <= lap_cnt_q;
              end
            end else if (dec_idx == idx_q) begin
              // Stalled counter: nothing moves.
              idx_q <= idx_q;
            end else begin
              // Legal but non-adjacent jump: drop lock, keep the lap count.
              step_err_q <= 1'b1;
              state_q    <= ST_ACQUIRE;
              valid_q    <= 1'b0;
              phase_q    <= {PHASES{1'b0}};
            end
          end
          ST_FAULT: begin
`ifdef JOHNSON_DEC_AUTO_RELOCK_EN
            if (dec_legal) begin
              // Relock directly; the sticky fault flag is left for clr_err.
              state_q <= ST_LOCKED;
              idx_q   <= dec_idx;
              phase_q <= onehot_f(dec_idx);
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_FAULT;
            end
`else
            state_q <= ST_FAULT;
`endif
          end
          default: begin
            state_q <= ST_ACQUIRE;
            valid_q <= 1'b0;
            phase_q <= {PHASES{1'b0}};
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign phase     = phase_q;
  assign phase_idx = idx_q;
  assign valid     = valid_q;
  assign lap_cnt   = lap_cnt_q;
  assign lap_pulse = lap_pulse_q;
  assign step_err  = step_err_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder (STAGES=4, LAP_W=8).
// A ring-level model predicts the outputs every cycle; directed sequences
// add hand-computed literal checks. Honours JOHNSON_DEC_AUTO_RELOCK_EN.

module tb_johnson_phase_decoder;

  logic       clk;
  logic       rs;
  logic       en;
  logic [3:0] jq;
  logic       clr_err;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       valid;
  logic [7:0] lap_cnt;
  logic       lap_pulse;
  logic       step_err;
  logic       fault;

  int total = 0;
  int bad   = 0;

  johnson_phase_decoder #(.STAGES(4), .LAP_W(8)) dut (
    .clk(clk), .rs(rs), .en(en), .jq(jq), .clr_err(clr_err),
    .phase(phase), .phase_idx(phase_idx), .valid(valid), .lap_cnt(lap_cnt),
    .lap_pulse(lap_pulse), .step_err(step_err), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ring position -> code, hand-written walk order
  logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // code -> ring position (-1 = illegal), built arithmetically from the ring rule
  int k_of [16];

  // model: mode 0 = acquiring, 1 = locked, 2 = faulted
  typedef struct packed {
    logic [1:0] mode;
    int         idx;
    int         lap;
    logic       lp;
    logic       se;
    logic       flt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step_f(input mdl_t cur, input logic e,
                                  input logic [3:0] code, input logic c);
    mdl_t n;
    int   k;
    n    = cur;
    n.lp = 1'b0;
    n.se = 1'b0;
    k    = k_of[code];
    if (c) begin
      n.mode = 2'd0;
      n.flt  = 1'b0;
    end else if (e) begin
      if (k < 0) begin
        if (cur.mode != 2'd2 || 1'b1) begin
          n.mode = 2'd2;
          n.flt  = 1'b1;
        end
      end else if (cur.mode == 2'd0) begin
        n.mode = 2'd1;
        n.idx  = k;
      end else if (cur.mode == 2'd1) begin
        if (k == (cur.idx + 1) % 8) begin
          n.idx = k;
          if (k == 0) begin
            n.lap = (cur.lap + 1) % 256;
            n.lp  = 1'b1;
          end
        end else if (k != cur.idx) begin
          n.se   = 1'b1;
          n.mode = 2'd0;
        end
      end else begin
`ifdef JOHNSON_DEC_AUTO_RELOCK_EN
        n.mode = 2'd1;
        n.idx  = k;
`else
        n.mode = 2'd2;
`endif
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model update, same sampling as the design
  always @(posedge clk or posedge rs) begin
    if (rs) m <= '{mode: 2'd0, idx: 0, lap: 0, lp: 1'b0, se: 1'b0, flt: 1'b0};
    else    m <= step_f(m, en, jq, clr_err);
  end

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic       ev;
    logic [7:0] ep;
    ev = (m.mode == 2'd1);
    ep = ev ? 8'(1 << m.idx) : 8'h00;
    chk("m_valid", {31'd0, valid}, {31'd0, ev});
    chk("m_phase", {24'd0, phase}, {24'd0, ep});
    chk("m_fault", {31'd0, fault}, {31'd0, m.flt});
    chk("m_lap_pulse", {31'd0, lap_pulse}, {31'd0, m.lp});
    chk("m_step_err", {31'd0, step_err}, {31'd0, m.se});
    chk("m_lap_cnt", {24'd0, lap_cnt}, 32'(m.lap));
    if (ev) chk("m_phase_idx", {29'd0, phase_idx}, 32'(m.idx));
  end

  task automatic drive(input logic e, input logic [3:0] c, input logic cl);
    @(negedge clk);
    en = e; jq = c; clr_err = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    for (int c = 0; c < 16; c++) k_of[c] = -1;
    for (int k = 0; k < 8; k++) begin
      int code;
      code = (k <= 4) ? ((1 << k) - 1) : (15 ^ ((1 << (k - 4)) - 1));
      k_of[code] = k;
    end

    rs = 1'b1; en = 1'b0; jq = 4'h0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_phase", {24'd0, phase}, 32'd0);
    chk("rst_idx", {29'd0, phase_idx}, 32'd0);
    chk("rst_lap", {24'd0, lap_cnt}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rs = 1'b0;

    // reset then lock, one full walk
    drive(1'b1, 4'h0, 1'b0);
    chk("lock_valid", {31'd0, valid}, 32'd1);
    chk("lock_phase", {24'd0, phase}, 32'h01);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, seq[k], 1'b0);
      chk("walk_phase", {24'd0, phase}, 32'(1 << k));
    end
    drive(1'b1, 4'h0, 1'b0);
    chk("walk_lap_pulse", {31'd0, lap_pulse}, 32'd1);
    chk("walk_lap_cnt", {24'd0, lap_cnt}, 32'd1);
    chk("walk_phase0", {24'd0, phase}, 32'h01);

    // 256 laps from a fresh lock wrap lap_cnt to 0
    @(negedge clk); rs = 1'b1; #2; rs = 1'b0;
    drive(1'b1, 4'h0, 1'b0);
    pulses = 0;
    for (int l = 0; l < 256; l++) begin
      for (int k = 1; k <= 8; k++) begin
        drive(1'b1, seq[k % 8], 1'b0);
        if (lap_pulse) pulses++;
      end
    end
    chk("wrap_pulses", 32'(pulses), 32'd256);
    chk("wrap_lap_cnt", {24'd0, lap_cnt}, 32'd0);
    chk("wrap_valid", {31'd0, valid}, 32'd1);

    // step error: lock at k=2, jump to k=5, relock at k=6
    drive(1'b0, 4'h0, 1'b1);
    chk("clr_valid", {31'd0, valid}, 32'd0);
    drive(1'b1, 4'h3, 1'b0);
    chk("se_lock_phase", {24'd0, phase}, 32'h04);
    drive(1'b1, 4'hE, 1'b0);
    chk("se_pulse", {31'd0, step_err}, 32'd1);
    chk("se_valid", {31'd0, valid}, 32'd0);
    drive(1'b1, 4'hC, 1'b0);
    chk("se_relock_valid", {31'd0, valid}, 32'd1);
    chk("se_relock_phase", {24'd0, phase}, 32'h40);
    chk("se_no_lap", {31'd0, lap_pulse}, 32'd0);
    chk("se_once", {31'd0, step_err}, 32'd0);

    // illegal code while locked at 0111
    drive(1'b1, 4'h7, 1'b0);
    chk("il_jump_se", {31'd0, step_err}, 32'd1);
    drive(1'b1, 4'h7, 1'b0);
    chk("il_lock_phase", {24'd0, phase}, 32'h08);
    drive(1'b1, 4'h5, 1'b0);
    chk("il_fault", {31'd0, fault}, 32'd1);
    chk("il_valid", {31'd0, valid}, 32'd0);
    chk("il_phase", {24'd0, phase}, 32'h00);
    drive(1'b1, 4'h0, 1'b0);
`ifdef JOHNSON_DEC_AUTO_RELOCK_EN
    chk("il_relock_valid", {31'd0, valid}, 32'd1);
    chk("il_relock_phase", {24'd0, phase}, 32'h01);
`else
    chk("il_stay_valid", {31'd0, valid}, 32'd0);
    chk("il_stay_phase", {24'd0, phase}, 32'h00);
`endif
    chk("il_sticky", {31'd0, fault}, 32'd1);
    drive(1'b1, 4'h1, 1'b1);
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_ignores_sample", {31'd0, valid}, 32'd0);
    drive(1'b1, 4'h1, 1'b0);
    chk("clr_relock_phase", {24'd0, phase}, 32'h02);

    // hold at 1111 and en gating
    drive(1'b1, 4'h3, 1'b0);
    drive(1'b1, 4'h7, 1'b0);
    drive(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'hF, 1'b0);
      chk("hold_phase", {24'd0, phase}, 32'h10);
      chk("hold_no_se", {31'd0, step_err}, 32'd0);
    end
    drive(1'b0, 4'h5, 1'b0);
    drive(1'b0, 4'h2, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h9, 1'b0);
    chk("gate_phase", {24'd0, phase}, 32'h10);
    chk("gate_idx", {29'd0, phase_idx}, 32'd4);
    chk("gate_valid", {31'd0, valid}, 32'd1);

    // walk round one lap to k=5, then async reset mid-lap
    for (int k = 5; k <= 13; k++) drive(1'b1, seq[k % 8], 1'b0);
    chk("pre_rst_lap", {24'd0, lap_cnt}, 32'd1);
    chk("pre_rst_phase", {24'd0, phase}, 32'h20);
    @(negedge clk);
    #2 rs = 1'b1;
    #1;
    chk("arst_phase", {24'd0, phase}, 32'd0);
    chk("arst_idx", {29'd0, phase_idx}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_lap", {24'd0, lap_cnt}, 32'd0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    #1 rs = 1'b0;
    drive(1'b1, 4'hE, 1'b0);
    chk("post_rst_phase", {24'd0, phase}, 32'h20);
    drive(1'b0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
